// File: rtl/fp_addsub_ctrl_if.sv
// Bundle of request, special-case checker, datapath and response signals
// around the FP add/sub controller; slave = controller, master = environment.

// Handshakes: a request transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. Once
// out_valid is raised, out_result/out_special/out_timeout hold until it transfers.
interface fp_addsub_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sc_enable;
  logic [31:0] sc_result;
  logic        dp_start;
  logic        dp_done;
  logic [31:0] dp_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_special;
  logic        out_timeout;
  logic        busy;

  modport slave (
    input  in_valid, in_a, in_b, in_op, sc_enable, sc_result,
           dp_done, dp_result, out_ready,
    output in_ready, op_a, op_b, dp_start, out_valid, out_result,
           out_special, out_timeout, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_op, sc_enable, sc_result,
           dp_done, dp_result, out_ready,
    input  in_ready, op_a, op_b, dp_start, out_valid, out_result,
           out_special, out_timeout, busy
  );
endinterface

// File: rtl/fp_addsub_ctrl.sv
// Sequencing controller for an IEEE-754 single add/sub: special-case bypass or
// datapath launch. Optional EXEC watchdog enabled by macro FP_CTRL_TIMEOUT_EN.
module fp_addsub_ctrl #(
  parameter int unsigned DP_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  fp_addsub_ctrl_if.slave  bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  logic        in_ready_q;
  logic        busy_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        dp_start_q;
  logic        out_valid_q;
  logic [31:0] out_result_q;
  logic        out_special_q;

`ifdef FP_CTRL_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(DP_TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_NAN = 32'h7FC0_0000;

  logic [7:0] exec_cnt;
  logic       out_timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      dp_start_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_special_q <= 1'b0;
      out_timeout_q <= 1'b0;
      exec_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a_q     <= bus.in_a;
            op_b_q     <= {bus.in_b[31] ^ bus.in_op, bus.in_b[30:0]};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (!bus.sc_enable) begin
            out_result_q  <= bus.sc_result;
            out_special_q <= 1'b1;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state         <= RESP;
          end else begin
            dp_start_q <= 1'b1;
            exec_cnt   <= '0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          dp_start_q <= 1'b0;
          // A completion on the limit cycle wins over the watchdog.
          if (bus.dp_done) begin
            out_result_q  <= bus.dp_result;
            out_special_q <= 1'b0;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state         <= RESP;
          end else if (exec_cnt == LIMIT) begin
            out_result_q  <= TIMEOUT_NAN;
            out_special_q <= 1'b0;
            out_timeout_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state         <= RESP;
          end else begin
            exec_cnt <= exec_cnt + 8'd1;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_timeout = out_timeout_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      dp_start_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_special_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a_q     <= bus.in_a;
            op_b_q     <= {bus.in_b[31] ^ bus.in_op, bus.in_b[30:0]};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (!bus.sc_enable) begin
            out_result_q  <= bus.sc_result;
            out_special_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state         <= RESP;
          end else begin
            dp_start_q <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          dp_start_q <= 1'b0;
          if (bus.dp_done) begin
            out_result_q  <= bus.dp_result;
            out_special_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_timeout = 1'b0;
`endif

  // The watchdog counter is 8 bits wide, so the limit must fit in 2..255.
  param_range_a : assert property (@(posedge clk) disable iff (rst)
    (DP_TIMEOUT >= 2) && (DP_TIMEOUT <= 255));

  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.dp_start    = dp_start_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_special = out_special_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Directed bench for fp_addsub_ctrl: vector table plus back-pressure and
// mid-EXEC reset sequences; timeout vectors depend on FP_CTRL_TIMEOUT_EN.
module tb_fp_addsub_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  fp_addsub_ctrl_if bus ();

  fp_addsub_ctrl #(.DP_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        sc_en;
    logic [31:0] sc_res;
    int          dp_delay;
    logic [31:0] dp_res;
    logic [31:0] exp_opb;
    logic [31:0] exp_res;
    logic        exp_special;
    logic        exp_timeout;
    int          exp_lat;
    int          exp_starts;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          pass_cnt  = 0;
  int          check_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          cyc;
    int          starts;
    int          start_cyc;
    bit          got;
    logic [31:0] exp;
    @(negedge clk);
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.in_op     = v.op;
    bus.sc_enable = v.sc_en;
    bus.sc_result = v.sc_res;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    check32({tag, " in_ready idle"}, {31'd0, bus.in_ready}, 32'd1);
    exp_q.push_back(v.exp_res);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1; starts = 0; start_cyc = -1; got = 0;
    check32({tag, " op_a"}, bus.op_a, v.a);
    check32({tag, " op_b"}, bus.op_b, v.exp_opb);
    while (cyc < 100) begin
      if (bus.dp_start) begin
        starts++;
        start_cyc = cyc;
      end
      if (bus.out_valid) begin
        got = 1;
        break;
      end
      if (start_cyc >= 0 && v.dp_delay >= 0 && cyc == start_cyc + v.dp_delay) begin
        bus.dp_done   = 1'b1;
        bus.dp_result = v.dp_res;
      end else begin
        bus.dp_done   = 1'b0;
        bus.dp_result = 32'hDEAD_0000 | 32'(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    bus.dp_done = 1'b0;
    check_int({tag, " out_valid seen"}, int'(got), 1);
    if (got) begin
      exp = exp_q.pop_front();
      check32({tag, " out_result"}, bus.out_result, exp);
      check32({tag, " out_special"}, {31'd0, bus.out_special}, {31'd0, v.exp_special});
      check32({tag, " out_timeout"}, {31'd0, bus.out_timeout}, {31'd0, v.exp_timeout});
      check_int({tag, " latency"}, cyc, v.exp_lat);
      check_int({tag, " dp_start pulses"}, starts, v.exp_starts);
      @(negedge clk);
      check32({tag, " back to idle"}, {30'd0, dbg_state}, 32'd0);
      check32({tag, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "bench watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 1'b0;
    bus.sc_enable = 1'b0;
    bus.sc_result = '0;
    bus.dp_done   = 1'b0;
    bus.dp_result = '0;
    bus.out_ready = 1'b0;

    //          a             b             op    sc_en sc_res        dly dp_res        exp_opb       exp_res       spc   to    lat st
    vecs.push_back('{32'h3F800000, 32'h00000000, 1'b0, 1'b0, 32'h3F800000, -1, 32'h0,        32'h00000000, 32'h3F800000, 1'b1, 1'b0, 2, 0});
    vecs.push_back('{32'h3F800000, 32'h40000000, 1'b1, 1'b1, 32'hDEADBEEF,  3, 32'hBF800000, 32'hC0000000, 32'hBF800000, 1'b0, 1'b0, 6, 1});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'hFF800001, -1, 32'h0,        32'hFF800000, 32'hFF800001, 1'b1, 1'b0, 2, 0});
    vecs.push_back('{32'h40400000, 32'hC0000000, 1'b1, 1'b1, 32'h0BADF00D,  0, 32'h40A00000, 32'h40000000, 32'h40A00000, 1'b0, 1'b0, 3, 1});
    vecs.push_back('{32'hC1200000, 32'h3F000000, 1'b0, 1'b1, 32'h12345678,  1, 32'hC1180000, 32'h3F000000, 32'hC1180000, 1'b0, 1'b0, 4, 1});
    vecs.push_back('{32'h7FC00000, 32'hBF800000, 1'b1, 1'b0, 32'h7FC00000, -1, 32'h0,        32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 2, 0});
`ifdef FP_CTRL_TIMEOUT_EN
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h0,        -1, 32'h0,        32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 10, 1});
    vecs.push_back('{32'h40000000, 32'h3F800000, 1'b1, 1'b1, 32'h0,         7, 32'h3F800000, 32'hBF800000, 32'h3F800000, 1'b0, 1'b0, 10, 1});
`else
    vecs.push_back('{32'h40000000, 32'h3F800000, 1'b1, 1'b1, 32'h0,        20, 32'h3F800000, 32'hBF800000, 32'h3F800000, 1'b0, 1'b0, 23, 1});
`endif

    repeat (3) @(negedge clk);
    check32("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check32("reset busy", {31'd0, bus.busy}, 32'd0);
    check32("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("reset dp_start", {31'd0, bus.dp_start}, 32'd0);
    check32("reset out_special", {31'd0, bus.out_special}, 32'd0);
    check32("reset out_timeout", {31'd0, bus.out_timeout}, 32'd0);
    check32("reset out_result", bus.out_result, 32'd0);
    check32("reset op_a", bus.op_a, 32'd0);
    check32("reset op_b", bus.op_b, 32'd0);
    check32("reset state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure in RESP with a competing request held on the input
    @(negedge clk);
    bus.in_a      = 32'h40490FDB;
    bus.in_b      = 32'h00000000;
    bus.in_op     = 1'b0;
    bus.sc_enable = 1'b0;
    bus.sc_result = 32'h40490FDB;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_a = 32'h11111111;
    @(negedge clk);
    check32("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
    check32("bp out_result", bus.out_result, 32'h40490FDB);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check32($sformatf("bp hold%0d out_valid", k), {31'd0, bus.out_valid}, 32'd1);
      check32($sformatf("bp hold%0d out_result", k), bus.out_result, 32'h40490FDB);
      check32($sformatf("bp hold%0d in_ready", k), {31'd0, bus.in_ready}, 32'd0);
      check32($sformatf("bp hold%0d op_a", k), bus.op_a, 32'h40490FDB);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check32("bp release out_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
    check32("bp no new capture", bus.op_a, 32'h40490FDB);

    // dp_done while idle must not move the FSM
    bus.dp_done = 1'b1;
    @(negedge clk);
    bus.dp_done = 1'b0;
    check32("idle dp_done ignored", {30'd0, dbg_state}, 32'd0);

    // Reset during EXEC, then a late dp_done
    bus.in_a      = 32'h3F800000;
    bus.in_b      = 32'h40000000;
    bus.in_op     = 1'b0;
    bus.sc_enable = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check32("rst-seq in EXEC", {30'd0, dbg_state}, 32'd2);
    check32("rst-seq dp_start", {31'd0, bus.dp_start}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check32("rst-seq async state", {30'd0, dbg_state}, 32'd0);
    check32("rst-seq async in_ready", {31'd0, bus.in_ready}, 32'd1);
    check32("rst-seq async busy", {31'd0, bus.busy}, 32'd0);
    check32("rst-seq async op_a", bus.op_a, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.dp_done   = 1'b1;
    bus.dp_result = 32'h40400000;
    @(negedge clk);
    bus.dp_done = 1'b0;
    check32("rst-seq late done state", {30'd0, dbg_state}, 32'd0);
    check32("rst-seq late done out_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("rst-seq late done out_result", bus.out_result, 32'd0);
    repeat (3) @(negedge clk);
    check32("rst-seq settle out_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("rst-seq settle in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_int("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
